// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
//   Match-level sequencer for the Pong datapath. Decides when the ball may
//   move, holds it at centre between rallies, chooses the serve direction,
//   keeps both scores, and declares the winner when a score reaches the limit.
//
// Ports:
//   i_Clk          system (pixel) clock
//   i_Rst          synchronous, active-high reset
//   i_Frame_Tick   one-cycle pulse per video frame
//   i_Game_Start   debounced start button (level; rising edge acts)
//   i_Pause        debounced pause button (level; rising edge acts)
//   i_Miss_P1      ball passed the P1 paddle (P2 scores)
//   i_Miss_P2      ball passed the P2 paddle (P1 scores)
//   o_Game_Active  ball motion enable (RUNNING only)
//   o_Ball_Reset   hold ball at centre (all states except RUNNING/PAUSED)
//   o_Serve_Dir    0 = serve toward P1, 1 = serve toward P2
//   o_P1_Score     P1 score
//   o_P2_Score     P2 score
//   o_Winner       00 none, 01 P1, 10 P2
//   o_State        state code for debug/display
// -----------------------------------------------------------------------------
module pong_match_ctrl #(
    parameter int c_SCORE_LIMIT  = 9,
    parameter int c_SERVE_FRAMES = 60,
    parameter int c_OVER_FRAMES  = 180,
    parameter int c_CNT_WIDTH    = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Frame_Tick,
    input  logic       i_Game_Start,
    input  logic       i_Pause,
    input  logic       i_Miss_P1,
    input  logic       i_Miss_P2,
    output logic       o_Game_Active,
    output logic       o_Ball_Reset,
    output logic       o_Serve_Dir,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic [1:0] o_Winner,
    output logic [2:0] o_State
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_SERVE     = 3'b001,
        ST_RUNNING   = 3'b010,
        ST_PAUSED    = 3'b011,
        ST_POINT     = 3'b100,
        ST_GAME_OVER = 3'b101
    } state_t;

    localparam logic [c_CNT_WIDTH-1:0] c_SERVE_LAST = c_CNT_WIDTH'(c_SERVE_FRAMES - 1);
    localparam logic [c_CNT_WIDTH-1:0] c_OVER_LAST  = c_CNT_WIDTH'(c_OVER_FRAMES - 1);
    localparam logic [3:0]             c_LIMIT      = 4'(c_SCORE_LIMIT);

    state_t                 state_q,      state_d;
    logic [c_CNT_WIDTH-1:0] cnt_q,        cnt_d;
    logic [3:0]             p1_score_q,   p1_score_d;
    logic [3:0]             p2_score_q,   p2_score_d;
    logic [1:0]             winner_q,     winner_d;
    logic                   serve_dir_q,  serve_dir_d;
    logic                   p2_scored_q,  p2_scored_d;   // 1 = P1 missed, P2 gets the point
    logic                   start_prev_q, pause_prev_q;
    logic                   edge_mask_q;                 // set for the first cycle after reset

    logic       start_rise, pause_rise;
    logic [3:0] p1_inc, p2_inc;

    // The mask stops a button that was held through reset from looking like
    // a fresh press on the first cycle after reset.
    assign start_rise = i_Game_Start & ~start_prev_q & ~edge_mask_q;
    assign pause_rise = i_Pause      & ~pause_prev_q & ~edge_mask_q;

    // The limit check in POINT ends the match before a score can reach 15+1,
    // so these increments never wrap.
    assign p1_inc = p1_score_q + 4'd1;
    assign p2_inc = p2_score_q + 4'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b0;
            p2_scored_q  <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            edge_mask_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            p2_scored_q  <= p2_scored_d;
            start_prev_q <= i_Game_Start;
            pause_prev_q <= i_Pause;
            edge_mask_q  <= 1'b0;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        p2_scored_d = p2_scored_q;

        unique case (state_q)
            ST_IDLE: begin
                // Start handling shared with GAME_OVER below.
            end

            ST_SERVE: begin
                if (i_Frame_Tick) begin
                    if (cnt_q == c_SERVE_LAST) begin
                        state_d = ST_RUNNING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_RUNNING: begin
                if (i_Miss_P1 && i_Miss_P2) begin
                    // Simultaneous miss is a dead ball: re-serve, no point.
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end else if (i_Miss_P1 || i_Miss_P2) begin
                    state_d     = ST_POINT;
                    p2_scored_d = i_Miss_P1;
                end else if (pause_rise) begin
                    state_d = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (pause_rise) begin
                    state_d = ST_RUNNING;
                end
            end

            ST_POINT: begin
                cnt_d = '0;
                if (p2_scored_q) begin
                    p2_score_d  = p2_inc;
                    serve_dir_d = 1'b0;
                    if (p2_inc == c_LIMIT) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else begin
                    p1_score_d  = p1_inc;
                    serve_dir_d = 1'b1;
                    if (p1_inc == c_LIMIT) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end

            ST_GAME_OVER: begin
                if (i_Frame_Tick) begin
                    if (cnt_q == c_OVER_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new match starts from IDLE or GAME_OVER; it overrides the
        // GAME_OVER timeout if both happen in the same cycle.
        if (start_rise && (state_q == ST_IDLE || state_q == ST_GAME_OVER)) begin
            state_d     = ST_SERVE;
            cnt_d       = '0;
            p1_score_d  = '0;
            p2_score_d  = '0;
            winner_d    = 2'b00;
            serve_dir_d = 1'b0;
        end
    end

    assign o_Game_Active = (state_q == ST_RUNNING);
    assign o_Ball_Reset  = (state_q != ST_RUNNING) && (state_q != ST_PAUSED);
    assign o_Serve_Dir   = serve_dir_q;
    assign o_P1_Score    = p1_score_q;
    assign o_P2_Score    = p2_score_q;
    assign o_Winner      = winner_q;
    assign o_State       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_match_ctrl
//   Directed walk through a full match followed by random button/miss/tick
//   traffic. Every cycle the DUT outputs are compared with a behavioural
//   match model built from the game rules.
// -----------------------------------------------------------------------------
module tb_pong_match_ctrl;

    localparam int SCORE_LIMIT  = 9;
    localparam int SERVE_FRAMES = 60;
    localparam int OVER_FRAMES  = 180;

    // Spec state codes
    localparam int IDLE = 0, SERVE = 1, RUNNING = 2, PAUSED = 3, POINT = 4, OVER = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pause = 1'b0, miss_p1 = 1'b0, miss_p2 = 1'b0;
    logic       game_active, ball_reset, serve_dir;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;
    logic [2:0] state;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model of the match
    int m_state = IDLE, m_cnt = 0, m_p1 = 0, m_p2 = 0, m_win = 0, m_dir = 0;
    bit m_p2_scores = 0;
    bit m_last_start = 0, m_last_pause = 0, m_last_rst = 0;

    pong_match_ctrl #(
        .c_SCORE_LIMIT (SCORE_LIMIT),
        .c_SERVE_FRAMES(SERVE_FRAMES),
        .c_OVER_FRAMES (OVER_FRAMES),
        .c_CNT_WIDTH   (8)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Frame_Tick (tick),
        .i_Game_Start (start),
        .i_Pause      (pause),
        .i_Miss_P1    (miss_p1),
        .i_Miss_P2    (miss_p2),
        .o_Game_Active(game_active),
        .o_Ball_Reset (ball_reset),
        .o_Serve_Dir  (serve_dir),
        .o_P1_Score   (p1_score),
        .o_P2_Score   (p2_score),
        .o_Winner     (winner),
        .o_State      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_match();
        m_state = SERVE; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
    endtask

    // Apply one cycle of inputs, advance the model by the game rules, then
    // compare every output just after the edge.
    task automatic step(input bit r, input bit t, input bit s, input bit p, input bit m1, input bit m2);
        bit s_rise, p_rise;
        rst = r; tick = t; start = s; pause = p; miss_p1 = m1; miss_p2 = m2;
        @(posedge clk);
        s_rise = s && !m_last_start && !m_last_rst;
        p_rise = p && !m_last_pause && !m_last_rst;
        if (r) begin
            m_state = IDLE; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
            m_last_start = 0; m_last_pause = 0; m_last_rst = 1;
        end else begin
            case (m_state)
                IDLE: if (s_rise) new_match();
                SERVE: if (t) begin
                    if (m_cnt == SERVE_FRAMES - 1) begin m_state = RUNNING; m_cnt = 0; end
                    else m_cnt++;
                end
                RUNNING: begin
                    if (m1 && m2)      begin m_state = SERVE; m_cnt = 0; end
                    else if (m1 || m2) begin m_state = POINT; m_p2_scores = m1; end
                    else if (p_rise)   m_state = PAUSED;
                end
                PAUSED: if (p_rise) m_state = RUNNING;
                POINT: begin
                    m_cnt = 0;
                    if (m_p2_scores) begin m_p2++; m_dir = 0; end
                    else             begin m_p1++; m_dir = 1; end
                    if (m_p1 == SCORE_LIMIT)      begin m_state = OVER; m_win = 1; end
                    else if (m_p2 == SCORE_LIMIT) begin m_state = OVER; m_win = 2; end
                    else                          m_state = SERVE;
                end
                OVER: begin
                    if (s_rise) new_match();
                    else if (t) begin
                        if (m_cnt == OVER_FRAMES - 1) begin m_state = IDLE; m_cnt = 0; end
                        else m_cnt++;
                    end
                end
                default: m_state = IDLE;
            endcase
            m_last_start = s; m_last_pause = p; m_last_rst = 0;
        end
        #1;
        check("state",      {1'b0, state},       4'(m_state));
        check("active",     {3'b0, game_active}, 4'(m_state == RUNNING));
        check("ball_reset", {3'b0, ball_reset},  4'(m_state != RUNNING && m_state != PAUSED));
        check("serve_dir",  {3'b0, serve_dir},   4'(m_dir));
        check("p1_score",   p1_score,            4'(m_p1));
        check("p2_score",   p2_score,            4'(m_p2));
        check("winner",     {2'b0, winner},      4'(m_win));
    endtask

    task automatic serve_out();
        repeat (SERVE_FRAMES) step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bit r_start, r_pause;

        // Reset with start held: the held button must not fire afterwards.
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        check("reset_state", {1'b0, state}, 4'd0);
        check("reset_score", p1_score | p2_score, 4'd0);
        step(0, 0, 1, 0, 0, 0);
        check("held_thru_rst", {1'b0, state}, 4'd0);
        step(0, 0, 0, 0, 0, 0);

        // Start press -> SERVE one cycle after the edge.
        step(0, 0, 1, 0, 0, 0);
        check("start_serve", {1'b0, state}, 4'd1);
        step(0, 0, 0, 0, 0, 0);

        // 59 ticks stay in SERVE, the 60th releases the ball.
        repeat (SERVE_FRAMES - 1) step(0, 1, 0, 0, 0, 0);
        check("serve_hold", {1'b0, state}, 4'd1);
        step(0, 1, 0, 0, 0, 0);
        check("serve_done", {1'b0, state}, 4'd2);
        check("run_active", {3'b0, game_active}, 4'd1);

        // P2 misses: POINT for one cycle, then P1 has 1 and serve toward P2.
        step(0, 0, 0, 0, 0, 1);
        check("point_state", {1'b0, state}, 4'd4);
        step(0, 0, 0, 0, 0, 0);
        check("p1_point", p1_score, 4'd1);
        check("dir_to_p2", {3'b0, serve_dir}, 4'd1);
        check("point_serve", {1'b0, state}, 4'd1);
        serve_out();

        // Simultaneous miss: re-serve, nothing changes.
        step(0, 0, 0, 0, 1, 1);
        check("dbl_state", {1'b0, state}, 4'd1);
        check("dbl_score", p1_score, 4'd1);
        serve_out();

        // Pause, ignored miss while paused, resume.
        step(0, 0, 0, 1, 0, 0);
        check("paused", {1'b0, state}, 4'd3);
        check("paused_reset", {3'b0, ball_reset}, 4'd0);
        step(0, 0, 0, 1, 1, 0);
        check("paused_miss", {1'b0, state}, 4'd3);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("resume", {1'b0, state}, 4'd2);
        step(0, 0, 0, 0, 0, 0);

        // P2 wins 9 straight points.
        for (int i = 0; i < SCORE_LIMIT; i++) begin
            if (i == SCORE_LIMIT - 1) check("p2_eight", p2_score, 4'd8);
            step(0, 0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0, 0);
            if (i < SCORE_LIMIT - 1) serve_out();
        end
        check("win_state", {1'b0, state}, 4'd5);
        check("win_p2", {2'b0, winner}, 4'd2);
        check("win_score", p2_score, 4'd9);
        repeat (OVER_FRAMES - 1) step(0, 1, 0, 0, 0, 0);
        check("over_hold", {1'b0, state}, 4'd5);
        step(0, 1, 0, 0, 0, 0);
        check("over_idle", {1'b0, state}, 4'd0);
        check("idle_keep", p2_score, 4'd9);

        // New match clears the board.
        step(0, 0, 1, 0, 0, 0);
        check("restart_score", p2_score, 4'd0);
        check("restart_win", {2'b0, winner}, 4'd0);
        step(0, 0, 0, 0, 0, 0);

        // Reach 3:5, then reset mid-SERVE.
        for (int i = 0; i < 8; i++) begin
            serve_out();
            step(0, 0, 0, 0, i >= 3, i < 3);
            step(0, 0, 0, 0, 0, 0);
        end
        repeat (10) step(0, 1, 0, 0, 0, 0);
        check("pre_rst_p1", p1_score, 4'd3);
        check("pre_rst_p2", p2_score, 4'd5);
        step(1, 1, 0, 0, 0, 0);
        check("rst_state", {1'b0, state}, 4'd0);
        check("rst_scores", p1_score | p2_score, 4'd0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic against the model.
        r_start = 0; r_pause = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 29) == 0) r_start = !r_start;
            if ($urandom_range(0, 39) == 0) r_pause = !r_pause;
            step($urandom_range(0, 2999) == 0, $urandom_range(0, 1) == 0, r_start, r_pause,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
